// File: rtl/spi_slave_axi_bridge.sv
// Turns decoded SPI slave words into single-beat AXI4 writes/reads, with address
// auto-increment across a continuous SPI burst and a one-word read prefetch.
module spi_slave_axi_bridge #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 4
) (
    input  logic                      axi_aclk,
    input  logic                      axi_aresetn,
    input  logic                      spi_active,
    input  logic [31:0]               spi_addr,
    input  logic                      spi_addr_valid,
    input  logic                      spi_rd_wr,
    input  logic [31:0]               rx_data,
    input  logic                      rx_valid,
    output logic                      rx_ready,
    output logic [31:0]               tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic [AXI_ADDR_WIDTH-1:0] axi_aw_addr,
    output logic                      axi_aw_valid,
    input  logic                      axi_aw_ready,
    output logic [AXI_ID_WIDTH-1:0]   axi_aw_id,
    output logic [7:0]                axi_aw_len,
    output logic [2:0]                axi_aw_size,
    output logic [1:0]                axi_aw_burst,
    output logic [31:0]               axi_w_data,
    output logic [3:0]                axi_w_strb,
    output logic                      axi_w_last,
    output logic                      axi_w_valid,
    input  logic                      axi_w_ready,
    input  logic                      axi_b_valid,
    input  logic [1:0]                axi_b_resp,
    output logic                      axi_b_ready,
    output logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr,
    output logic                      axi_ar_valid,
    input  logic                      axi_ar_ready,
    output logic [AXI_ID_WIDTH-1:0]   axi_ar_id,
    output logic [7:0]                axi_ar_len,
    output logic [2:0]                axi_ar_size,
    output logic [1:0]                axi_ar_burst,
    input  logic [31:0]               axi_r_data,
    input  logic [1:0]                axi_r_resp,
    input  logic                      axi_r_valid,
    input  logic                      axi_r_last,
    output logic                      axi_r_ready,
    output logic                      bus_err
);
    localparam int unsigned AW = AXI_ADDR_WIDTH;
    localparam int unsigned DW = 32;

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RD_HOLD
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, xfer_addr_q;
    logic            mode_q, reload_q;
    logic            aw_valid_q, w_valid_q, ar_valid_q, b_ready_q, r_ready_q;
    logic            tx_valid_q, bus_err_q;
    logic [DW-1:0]   w_data_q, tx_data_q;
    logic            aw_hs, w_hs, ar_hs, b_hs, r_hs, resp_err;
    logic            issue_wr, issue_rd;
    logic            unused_r_last;

    assign aw_hs    = aw_valid_q & axi_aw_ready;
    assign w_hs     = w_valid_q & axi_w_ready;
    assign ar_hs    = ar_valid_q & axi_ar_ready;
    assign b_hs     = b_ready_q & axi_b_valid;
    assign r_hs     = r_ready_q & axi_r_valid;
    assign resp_err = (b_hs & (axi_b_resp != 2'b00)) | (r_hs & (axi_r_resp != 2'b00));

    // Next-state logic; a fresh SPI address pulse defers new issue by one cycle
    always_comb begin
        state_d  = state_q;
        issue_wr = 1'b0;
        issue_rd = 1'b0;
        case (state_q)
            IDLE: begin
                if (!spi_addr_valid) begin
                    if (!mode_q && rx_valid) begin
                        state_d  = WR_REQ;
                        issue_wr = 1'b1;
                    end else if (mode_q && spi_active && !tx_valid_q) begin
                        state_d  = RD_REQ;
                        issue_rd = 1'b1;
                    end
                end
            end
            WR_REQ: begin
                if ((!aw_valid_q || axi_aw_ready) && (!w_valid_q || axi_w_ready))
                    state_d = WR_RESP;
            end
            WR_RESP: if (b_hs)     state_d = IDLE;
            RD_REQ:  if (ar_hs)    state_d = RD_RESP;
            RD_RESP: if (r_hs)     state_d = RD_HOLD;
            RD_HOLD: if (tx_ready) state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) state_q <= IDLE;
        else              state_q <= state_d;
    end

    // AXI request/response channel registers
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            b_ready_q   <= 1'b0;
            r_ready_q   <= 1'b0;
            xfer_addr_q <= '0;
            w_data_q    <= '0;
        end else begin
            if (issue_wr) begin
                aw_valid_q  <= 1'b1;
                w_valid_q   <= 1'b1;
                w_data_q    <= rx_data;
                xfer_addr_q <= addr_q;
            end else begin
                if (aw_hs) aw_valid_q <= 1'b0;
                if (w_hs)  w_valid_q  <= 1'b0;
            end
            if (issue_rd) begin
                ar_valid_q  <= 1'b1;
                xfer_addr_q <= addr_q;
            end else if (ar_hs) begin
                ar_valid_q <= 1'b0;
            end
            b_ready_q <= (state_d == WR_RESP);
            r_ready_q <= (state_d == RD_RESP);
        end
    end

    // A new SPI address arriving mid-transaction suppresses that transaction's increment
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            addr_q    <= '0;
            mode_q    <= 1'b0;
            reload_q  <= 1'b0;
            bus_err_q <= 1'b0;
        end else if (spi_addr_valid) begin
            addr_q    <= AW'(spi_addr);
            mode_q    <= spi_rd_wr;
            reload_q  <= (state_q != IDLE) && !(b_hs || r_hs);
            bus_err_q <= 1'b0;
        end else begin
            if (b_hs || r_hs) begin
                if (!reload_q) addr_q <= addr_q + AW'(4);
                reload_q <= 1'b0;
            end
            if (resp_err) bus_err_q <= 1'b1;
        end
    end

    // Read word slot towards the TX FIFO
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else if (r_hs) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= axi_r_data;
        end else if (tx_valid_q && tx_ready) begin
            tx_valid_q <= 1'b0;
        end
    end

    // RX pop must coincide with the W handshake itself
    assign rx_ready      = w_hs;
    assign tx_valid      = tx_valid_q;
    assign tx_data       = tx_data_q;
    assign bus_err       = bus_err_q;

    assign axi_aw_addr   = xfer_addr_q;
    assign axi_aw_valid  = aw_valid_q;
    assign axi_aw_id     = AXI_ID_WIDTH'(0);
    assign axi_aw_len    = 8'd0;
    assign axi_aw_size   = 3'b010;
    assign axi_aw_burst  = 2'b01;
    assign axi_w_data    = w_data_q;
    assign axi_w_strb    = 4'hF;
    assign axi_w_last    = 1'b1;
    assign axi_w_valid   = w_valid_q;
    assign axi_b_ready   = b_ready_q;
    assign axi_ar_addr   = xfer_addr_q;
    assign axi_ar_valid  = ar_valid_q;
    assign axi_ar_id     = AXI_ID_WIDTH'(0);
    assign axi_ar_len    = 8'd0;
    assign axi_ar_size   = 3'b010;
    assign axi_ar_burst  = 2'b01;
    assign axi_r_ready   = r_ready_q;
    assign unused_r_last = axi_r_last;
endmodule
